// File: rtl/seq_pkg.sv
// Shared types and constants for the Y86-64 SEQ sequencer.
// Holds the state enum, status codes, icodes, stage_en bit map and needs_mem().
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam int SE_F   = 0;
  localparam int SE_D   = 1;
  localparam int SE_E   = 2;
  localparam int SE_M   = 3;
  localparam int SE_W   = 4;
  localparam int SE_PCU = 5;

  function automatic logic needs_mem(input logic [3:0] ic);
    logic r;
    r = 1'b0;
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL,
      I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_stage_controller_next_pc.sv
// seq_next_pc: combinational next-PC select for SEQ (and later the pipeline).
// Ports: icode_i, cnd_i, valc_i, valm_i, valp_i -> next_pc_o.
module seq_next_pc
  import seq_pkg::*;
(
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic [63:0] valc_i,
  input  logic [63:0] valm_i,
  input  logic [63:0] valp_i,
  output logic [63:0] next_pc_o
);

  always_comb begin
    next_pc_o = valp_i;
    unique case (1'b1)
      (icode_i == I_CALL):         next_pc_o = valc_i;
      (icode_i == I_JXX) && cnd_i: next_pc_o = valc_i;
      (icode_i == I_RET):          next_pc_o = valm_i;
      default:                     next_pc_o = valp_i;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ sequencer: owns PC/stat, walks F-D-E-M-W-PCU one-hot enables.
// Ports: start, fetch/exec/mem results in; pc, stage_en, dmem_req, stat, busy,
// retire, cycle_cnt, instr_cnt out. Counters live only with SEQ_PERF_COUNTERS_EN.
module seq_stage_controller
  import seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int unsigned IMEM_BYTES  = 1024,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        hlt,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic        cnd,
  input  logic [63:0] valM,
  input  logic        dmem_ack,
  input  logic        dmem_error,
  output logic [63:0] pc,
  output logic [5:0]  stage_en,
  output logic        dmem_req,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  localparam logic [63:0] IMEM_LIM = 64'(IMEM_BYTES);
  localparam logic [7:0]  TO_LIM   = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_q, icode_d;
  logic        hlt_q, hlt_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic [63:0] next_pc;

  seq_next_pc u_next_pc (
    .icode_i   (icode_q),
    .cnd_i     (cnd),
    .valc_i    (valC),
    .valm_i    (valM),
    .valp_i    (valP),
    .next_pc_o (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      icode_q <= I_NOP;
      hlt_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      hlt_q   <= hlt_d;
      wait_q  <= wait_d;
    end
  end

  assign wait_inc = wait_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    hlt_d   = hlt_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error || (pc_q >= IMEM_LIM)) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALTED;
        end else begin
          icode_d = icode;
          hlt_d   = hlt;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = needs_mem(icode_q) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        wait_d = wait_inc;
        // ack wins over a timeout landing in the same cycle
        if (dmem_ack) begin
          wait_d = '0;
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_inc == TO_LIM) begin
          wait_d  = '0;
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        if ((icode_q == I_HALT) || hlt_q) begin
          stat_d  = STAT_HLT;
          pc_d    = valP;
          state_d = S_HALTED;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stage_en = '0;
    unique case (state_q)
      S_FETCH:     stage_en[SE_F]   = 1'b1;
      S_DECODE:    stage_en[SE_D]   = 1'b1;
      S_EXECUTE:   stage_en[SE_E]   = 1'b1;
      S_MEMORY:    stage_en[SE_M]   = 1'b1;
      S_WRITEBACK: stage_en[SE_W]   = 1'b1;
      S_PCUPD:     stage_en[SE_PCU] = 1'b1;
      default:     stage_en = '0;
    endcase
  end

  assign pc       = pc_q;
  assign stat     = stat_q;
  assign dmem_req = (state_q == S_MEMORY);
  assign retire   = (state_q == S_PCUPD);
  assign busy     = (state_q != S_IDLE) &&
                    (state_q != S_HALTED);

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ins_q, ins_d;

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (busy)   cyc_d = cyc_q + 32'd1;
    if (retire) ins_d = ins_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
